// File: rtl/button_emulator.sv
`default_nettype none
// ============================================================================
// Module   : button_emulator
// Purpose  : Synthesises active-low power / reset button presses on command,
//            timed in 125 ms strobes, followed by a mandatory released gap so
//            every emulated press is cleanly seen by the downstream debouncer.
// Options  : BTN_EMU_PHYS_LOCKOUT_EN - when defined, a physical press blocks
//            new commands and cuts an emulated press short.
// Revision : 1.0 - initial release
// ============================================================================
module button_emulator #(
  parameter int unsigned SHORT_TICKS = 4,
  parameter int unsigned LONG_TICKS  = 48,
  parameter int unsigned RESET_TICKS = 2,
  parameter int unsigned GAP_TICKS   = 2
) (
  input  logic       SlowClock,
  input  logic       MainReset,
  input  logic       Strobe16ms,
  input  logic       Strobe125ms,
  input  logic       CmdValid,
  input  logic [1:0] CmdCode,
  input  logic       CmdAbort,
  input  logic       PhysPressed,
  output logic       CmdAccept,
  output logic       Busy,
  output logic       Done,
  output logic       Aborted,
  output logic       PowerButtonEmu,
  output logic       SysResetEmu
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [1:0] CODE_RESET = 2'b11;

  localparam logic [5:0] C_SHORT_LD = 6'(SHORT_TICKS);
  localparam logic [5:0] C_LONG_LD  = 6'(LONG_TICKS);
  localparam logic [5:0] C_RESET_LD = 6'(RESET_TICKS);
  localparam logic [5:0] C_GAP_LD   = 6'(GAP_TICKS);

  logic [1:0] state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [5:0] timer_q, timer_d;
  logic       accept_q, accept_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic       pwr_n_q, pwr_n_d;
  logic       rst_n_q, rst_n_d;

  logic       w_phys;
  logic       w_last_tick;
  logic       w_cut;
  logic [5:0] w_press_ld;

`ifdef BTN_EMU_PHYS_LOCKOUT_EN
  assign w_phys = PhysPressed;
  logic unused_inputs;
  assign unused_inputs = Strobe16ms;
`else
  // Physical button state is deliberately ignored; presses may overlap.
  assign w_phys = 1'b0;
  logic unused_inputs;
  assign unused_inputs = Strobe16ms ^ PhysPressed;
`endif

  // The strobe that takes Timer from 1 to 0 ends the current phase on that
  // same edge, which gives a low time in ((K-1)*T, K*T].
  assign w_last_tick = Strobe125ms && (timer_q == 6'd1);
  assign w_cut       = CmdAbort || w_phys;

  // Press length selected by the incoming command code.
  always_comb begin
    w_press_ld = C_RESET_LD;
    case (CmdCode)
      2'b01:   w_press_ld = C_SHORT_LD;
      2'b10:   w_press_ld = C_LONG_LD;
      default: w_press_ld = C_RESET_LD;
    endcase
  end

  // Next-state logic; every output is computed here and registered below.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    timer_d   = timer_q;
    aborted_d = aborted_q;
    accept_d  = 1'b0;
    done_d    = 1'b0;
    pwr_n_d   = 1'b1;
    rst_n_d   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (CmdValid && (CmdCode != 2'b00) && !w_cut) begin
          state_d   = ST_PRESS;
          code_d    = CmdCode;
          timer_d   = w_press_ld;
          accept_d  = 1'b1;
          aborted_d = 1'b0;
          pwr_n_d   = (CmdCode == CODE_RESET);
          rst_n_d   = (CmdCode != CODE_RESET);
        end
      end

      ST_PRESS: begin
        if (w_cut) begin
          // Abort takes priority over a coincident final strobe.
          state_d   = ST_GAP;
          timer_d   = C_GAP_LD;
          aborted_d = 1'b1;
        end else if (w_last_tick) begin
          state_d = ST_GAP;
          timer_d = C_GAP_LD;
        end else begin
          if (Strobe125ms) begin
            timer_d = timer_q - 6'd1;
          end
          pwr_n_d = (code_q == CODE_RESET);
          rst_n_d = (code_q != CODE_RESET);
        end
      end

      ST_GAP: begin
        // Done is raised while still Busy; the following edge returns to IDLE.
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (w_last_tick) begin
          timer_d = 6'd0;
          done_d  = 1'b1;
        end else if (Strobe125ms) begin
          timer_d = timer_q - 6'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = 6'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset releases both buttons immediately.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset) begin
      state_q   <= ST_IDLE;
      code_q    <= 2'b00;
      timer_q   <= 6'd0;
      accept_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pwr_n_q   <= 1'b1;
      rst_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      timer_q   <= timer_d;
      accept_q  <= accept_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      pwr_n_q   <= pwr_n_d;
      rst_n_q   <= rst_n_d;
    end
  end

  assign CmdAccept      = accept_q;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign Aborted        = aborted_q;
  assign PowerButtonEmu = pwr_n_q;
  assign SysResetEmu    = rst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_button_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_emulator
// Purpose  : Self-checking bench for button_emulator. The 125 ms strobe is
//            generated every P clocks so long presses stay short in cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_emulator;

  localparam int P      = 16;
  localparam int SHORT  = 4;
  localparam int LONG   = 48;
  localparam int RSTK   = 2;
  localparam int GAPK   = 2;
`ifdef BTN_EMU_PHYS_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       SlowClock = 1'b0;
  logic       MainReset;
  logic       Strobe16ms;
  logic       Strobe125ms;
  logic       CmdValid;
  logic [1:0] CmdCode;
  logic       CmdAbort;
  logic       PhysPressed;
  logic       CmdAccept, Busy, Done, Aborted, PowerButtonEmu, SysResetEmu;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  button_emulator #(
    .SHORT_TICKS(SHORT), .LONG_TICKS(LONG), .RESET_TICKS(RSTK), .GAP_TICKS(GAPK)
  ) dut (
    .SlowClock(SlowClock), .MainReset(MainReset), .Strobe16ms(Strobe16ms),
    .Strobe125ms(Strobe125ms), .CmdValid(CmdValid), .CmdCode(CmdCode),
    .CmdAbort(CmdAbort), .PhysPressed(PhysPressed), .CmdAccept(CmdAccept),
    .Busy(Busy), .Done(Done), .Aborted(Aborted),
    .PowerButtonEmu(PowerButtonEmu), .SysResetEmu(SysResetEmu)
  );

  always #5 SlowClock = ~SlowClock;

  typedef struct {
    logic [1:0] code;
    int         abort_at;  // abort sampled this many edges after accept (0 = none)
    int         phys_at;   // physical press rises this many edges after accept
    bit         phys_pre;  // physical press already held when command is issued
    bit         exp_acc;
    int         lo_min;
    int         lo_max;
    bit         exp_abt;
  } vec_t;

  vec_t tbl[8];

  // Strobe for the upcoming edge, then advance one clock and park on negedge.
  task automatic tick();
    Strobe125ms = ((cyc + 1) % P == 0);
    Strobe16ms  = ((cyc + 1) % 4 == 0);
    @(posedge SlowClock);
    cyc++;
    @(negedge SlowClock);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Apply one table command and measure low time and gap length.
  task automatic run_entry(input int idx, input vec_t v);
    int  n, lo_p, lo_r, lo, nd, pre;
    bit  acc, dn;
    string s;
    s   = $sformatf("v%0d", idx);
    pre = int'($urandom_range(1, P));
    for (int j = 0; j < pre; j++) tick();
    CmdCode     = v.code;
    CmdValid    = 1'b1;
    PhysPressed = v.phys_pre;
    acc         = 1'b0;
    for (int j = 0; j < 4 && !acc; j++) begin
      tick();
      acc = CmdAccept;
    end
    CmdValid = 1'b0;
    CmdCode  = 2'b00;
    chk({s, "_accept"}, 32'(acc), 32'(v.exp_acc));
    if (!acc) begin
      repeat (3) tick();
      chk({s, "_idle_busy"}, 32'(Busy), 0);
      chk({s, "_idle_pwr"}, 32'(PowerButtonEmu), 1);
      chk({s, "_idle_rst"}, 32'(SysResetEmu), 1);
      PhysPressed = 1'b0;
      return;
    end
    lo_p = PowerButtonEmu ? 0 : 1;
    lo_r = SysResetEmu ? 0 : 1;
    n = 0; dn = 1'b0; nd = 0;
    while (!dn && n < 2000) begin
      CmdAbort = (v.abort_at != 0 && n + 1 == v.abort_at);
      if (v.phys_at != 0 && n + 1 == v.phys_at) PhysPressed = 1'b1;
      tick();
      n++;
      CmdAbort = 1'b0;
      if (n == 1) chk({s, "_accept_pulse"}, 32'(CmdAccept), 0);
      if (!PowerButtonEmu) lo_p++;
      if (!SysResetEmu) lo_r++;
      if (Done) begin
        dn = 1'b1;
        nd = n;
      end
    end
    chk({s, "_done_seen"}, 32'(dn), 1);
    if (v.code == 2'b11) begin
      lo = lo_r;
      chk({s, "_other_low"}, 32'(lo_p), 0);
    end else begin
      lo = lo_p;
      chk({s, "_other_low"}, 32'(lo_r), 0);
    end
    chk_rng({s, "_low_time"}, lo, v.lo_min, v.lo_max);
    chk_rng({s, "_gap_time"}, nd - lo, (GAPK - 1) * P + 1, GAPK * P);
    chk({s, "_busy_at_done"}, 32'(Busy), 1);
    chk({s, "_aborted"}, 32'(Aborted), 32'(v.exp_abt));
    tick();
    chk({s, "_busy_after"}, 32'(Busy), 0);
    chk({s, "_done_pulse"}, 32'(Done), 0);
    PhysPressed = 1'b0;
  endtask

  // Reference model: press/gap end points computed from the strobe schedule.
  int         m_a, m_pe, m_de;
  logic [1:0] m_k;
  bit         m_ab;

  function automatic int kt(input logic [1:0] c);
    case (c)
      2'b01:   return SHORT;
      2'b10:   return LONG;
      2'b11:   return RSTK;
      default: return 0;
    endcase
  endfunction

  // Edge of the k-th strobe strictly after edge s (strobes land on multiples of P).
  function automatic int nth_strobe(input int s, input int k);
    return (s / P + 1) * P + (k - 1) * P;
  endfunction

  task automatic model_init();
    m_a = -100; m_pe = -100; m_de = -100; m_k = 2'b00; m_ab = 1'b0;
  endtask

  task automatic model_step(input int e, input bit v, input logic [1:0] c,
                            input bit ab, input bit ph);
    bit in_press, in_gap, cut;
    in_press = (m_a < e) && (e <= m_pe);
    in_gap   = (m_pe < e) && (e <= m_de + 1);
    cut      = ab || (LOCK && ph);
    if (!in_press && !in_gap) begin
      if (v && c != 2'b00 && !cut) begin
        m_a  = e;
        m_k  = c;
        m_pe = nth_strobe(e, kt(c));
        m_de = nth_strobe(m_pe, GAPK);
        m_ab = 1'b0;
      end
    end else if (in_press && cut) begin
      m_pe = e;
      m_de = nth_strobe(e, GAPK);
      m_ab = 1'b1;
    end
  endtask

  initial begin
    int  acc_cnt, w, e;
    bit  rv, ra, rp;
    logic [1:0] rc;
    vec_t vr;

    MainReset = 1'b0; CmdValid = 1'b0; CmdCode = 2'b00; CmdAbort = 1'b0;
    PhysPressed = 1'b0; Strobe125ms = 1'b0; Strobe16ms = 1'b0;

    tbl[0] = '{2'd1, 0,  0, 1'b0, 1'b1, (SHORT - 1) * P + 1, SHORT * P, 1'b0};
    tbl[1] = '{2'd2, 0,  0, 1'b0, 1'b1, (LONG - 1) * P + 1,  LONG * P,  1'b0};
    tbl[2] = '{2'd3, 0,  0, 1'b0, 1'b1, (RSTK - 1) * P + 1,  RSTK * P,  1'b0};
    tbl[3] = '{2'd3, 11, 0, 1'b0, 1'b1, 11, 11, 1'b1};
    tbl[4] = '{2'd1, 0,  0, 1'b0, 1'b1, (SHORT - 1) * P + 1, SHORT * P, 1'b0};
    tbl[5] = '{2'd0, 0,  0, 1'b0, 1'b0, 0, 0, 1'b0};
    if (LOCK) begin
      tbl[6] = '{2'd1, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0};
      tbl[7] = '{2'd1, 0, 5, 1'b0, 1'b1, 5, 5, 1'b1};
    end else begin
      tbl[6] = '{2'd1, 0, 0, 1'b1, 1'b1, (SHORT - 1) * P + 1, SHORT * P, 1'b0};
      tbl[7] = '{2'd1, 0, 5, 1'b0, 1'b1, (SHORT - 1) * P + 1, SHORT * P, 1'b0};
    end

    // Reset values
    repeat (3) tick();
    chk("rst_accept", 32'(CmdAccept), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_aborted", 32'(Aborted), 0);
    chk("rst_pwr", 32'(PowerButtonEmu), 1);
    chk("rst_sysrst", 32'(SysResetEmu), 1);
    MainReset = 1'b1;
    tick();

    // Table-driven commands
    for (int i = 0; i < 8; i++) run_entry(i, tbl[i]);

    // Command while busy is ignored; valid+abort in IDLE is refused
    CmdValid = 1'b1; CmdCode = 2'b01; acc_cnt = 0;
    for (int j = 0; j < 4 && acc_cnt == 0; j++) begin
      tick();
      if (CmdAccept) acc_cnt++;
    end
    chk("busy_first_accept", 32'(acc_cnt), 1);
    acc_cnt = 0;
    repeat (30) begin
      tick();
      if (CmdAccept) acc_cnt++;
    end
    chk("busy_no_accept", 32'(acc_cnt), 0);
    chk("busy_pwr_low", 32'(PowerButtonEmu), 0);
    chk("busy_sysrst_high", 32'(SysResetEmu), 1);
    CmdValid = 1'b0; CmdCode = 2'b00; CmdAbort = 1'b1;
    tick();
    CmdAbort = 1'b0;
    chk("abort_release", 32'(PowerButtonEmu), 1);
    chk("abort_sticky", 32'(Aborted), 1);
    w = 0;
    while (!Done && w < 200) begin
      tick();
      w++;
    end
    chk("abort_done_seen", 32'(Done), 1);
    tick();
    CmdValid = 1'b1; CmdCode = 2'b01; CmdAbort = 1'b1;
    tick();
    chk("valid_abort_no_accept", 32'(CmdAccept), 0);
    chk("valid_abort_busy", 32'(Busy), 0);
    CmdValid = 1'b0; CmdCode = 2'b00; CmdAbort = 1'b0;
    tick();

    // Asynchronous reset in the middle of a long press
    CmdValid = 1'b1; CmdCode = 2'b10; acc_cnt = 0;
    for (int j = 0; j < 4 && acc_cnt == 0; j++) begin
      tick();
      if (CmdAccept) acc_cnt++;
    end
    CmdValid = 1'b0; CmdCode = 2'b00;
    repeat (20) tick();
    chk("mid_press_low", 32'(PowerButtonEmu), 0);
    MainReset = 1'b0;
    #1;
    chk("areset_pwr", 32'(PowerButtonEmu), 1);
    chk("areset_busy", 32'(Busy), 0);
    repeat (2) tick();
    MainReset = 1'b1;
    tick();
    vr = '{2'd3, 0, 0, 1'b0, 1'b1, (RSTK - 1) * P + 1, RSTK * P, 1'b0};
    run_entry(8, vr);

    // Randomised traffic against the reference model
    MainReset = 1'b0;
    repeat (2) tick();
    MainReset = 1'b1;
    model_init();
    for (int k = 0; k < 6000; k++) begin
      rv = ($urandom_range(0, 3) == 0);
      rc = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 49) == 0);
      rp = ($urandom_range(0, 79) == 0);
      CmdValid = rv; CmdCode = rc; CmdAbort = ra; PhysPressed = rp;
      e = cyc + 1;
      model_step(e, rv, rc, ra, rp);
      tick();
      chk("rnd_accept", 32'(CmdAccept), 32'(m_a == e));
      chk("rnd_busy", 32'(Busy), 32'(m_a <= e && e <= m_de));
      chk("rnd_done", 32'(Done), 32'(e == m_de));
      chk("rnd_aborted", 32'(Aborted), 32'(m_ab));
      chk("rnd_pwr", 32'(PowerButtonEmu), 32'(!(m_a <= e && e < m_pe && m_k != 2'b11)));
      chk("rnd_sysrst", 32'(SysResetEmu), 32'(!(m_a <= e && e < m_pe && m_k == 2'b11)));
    end
    CmdValid = 1'b0; CmdCode = 2'b00; CmdAbort = 1'b0; PhysPressed = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
